aer_spike_encoder: RTL and testbench

- Transmit side of the AER link for the post-synaptic layer: converts the per-word 4-bit spike vector from the neuron core into serial AER address events on a 4-phase REQ/ACK interface.
- Sits between the neuron core's event outputs and the off-core AER bus.
- Buffers spike words in a FIFO so the core never stalls, and inserts time-step marker events.

---
 rtl/aer_pkg.sv | 37 +++
 rtl/aer_spike_encoder_if.sv | 12 +
 rtl/aer_evt_fifo.sv | 45 ++++
 rtl/aer_spike_encoder.sv | 167 ++++++++++++++++
 tb/tb_aer_spike_encoder.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aer_pkg.sv
// Shared types for the AER transmit path: FIFO entry layout, event address layout, FSM states.
// No logic here; latency and backpressure belong to the modules that import it.
package aer_pkg;

    localparam int MASK_W          = 4;
    localparam int BASE_W          = 8;
    localparam int ENTRY_W         = 1 + BASE_W + MASK_W;
    localparam int AER_ADDR_W      = 11;
    localparam int ADDR_MARKER_BIT = 10;
    localparam logic [7:0] DROP_SAT = 8'hFF;

    // marker occupies bit 12, base [11:4], mask [3:0]
    typedef struct packed {
        logic              marker;
        logic [BASE_W-1:0] base;
        logic [MASK_W-1:0] mask;
    } aer_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEL    = 2'd1,
        ST_REQ_HI = 2'd2,
        ST_ACK_LO = 2'd3
    } aer_state_t;

    localparam aer_entry_t MARKER_ENTRY = '{marker: 1'b1, base: '0, mask: '0};

    function automatic logic [AER_ADDR_W-1:0] event_addr(input aer_entry_t e,
                                                          input logic [1:0] bit_idx);
        logic [AER_ADDR_W-1:0] a;
        a = '0;
        if (e.marker) a[ADDR_MARKER_BIT] = 1'b1;
        else          a = {1'b0, e.base, bit_idx};
        return a;
    endfunction

endpackage

// File: rtl/aer_spike_encoder_if.sv
// 4-phase AER link: REQ/ADDR from the encoder, ACK back from the (asynchronous) receiver.
// Pure wiring; the encoder holds ADDR stable for the whole time REQ is high.
interface aer_spike_encoder_if;
    import aer_pkg::*;

    logic                  AER_REQ;
    logic [AER_ADDR_W-1:0] AER_ADDR;
    logic                  AER_ACK;

    modport master (output AER_REQ, AER_ADDR, input AER_ACK);
    modport slave  (input AER_REQ, AER_ADDR, output AER_ACK);
endinterface

// File: rtl/aer_evt_fifo.sv
// Synchronous FIFO with wrap-bit pointers; push visible on rd_dat the cycle after the write.
// Push while full is ignored (full is pre-pop occupancy); pop while empty is ignored.
module aer_evt_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_dat  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end

endmodule

// File: rtl/aer_spike_encoder.sv
// Spike words -> serial 4-phase AER events plus time-step markers; first REQ 2 cycles after the word.
// Never stalls the core: words arriving into a full FIFO are dropped and counted; markers wait.
module aer_spike_encoder
    import aer_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic [MASK_W-1:0]       NEUR_EVENT_OUT,
    input  logic [9:0]              CTRL_POST_NEURON_ADDRESS,
    input  logic                    CTRL_TSTEP_EVENT,
    input  logic                    SPI_GATE_ACTIVITY_sync,
    input  logic                    CLR_STATUS,
    aer_spike_encoder_if.master     aer,
    output logic                    AER_BUSY,
    output logic                    FIFO_EMPTY,
    output logic                    OVERFLOW,
    output logic [7:0]              DROP_CNT
);
    logic       ack_meta, ack_s;
    logic       tstep_q, marker_pend;
    logic       tstep_rise, spike_wr, marker_wr, drop;
    logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
    aer_entry_t wr_entry, rd_entry;
    logic       overflow_q;
    logic [7:0] drop_cnt_q;

    aer_state_t            state_q, state_d;
    aer_entry_t            ser_q, ser_d;
    logic                  req_q, req_d;
    logic [AER_ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]            low_idx;
    logic [MASK_W-1:0]     low_bit;

    // word base comes from bits [9:2]; the two LSBs select a neuron we already get as a vector
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^CTRL_POST_NEURON_ADDRESS[1:0];

    assign tstep_rise = CTRL_TSTEP_EVENT && !tstep_q;
    assign spike_wr   = (|NEUR_EVENT_OUT) && !SPI_GATE_ACTIVITY_sync;
    assign marker_wr  = marker_pend && !spike_wr && !fifo_full;
    assign drop       = spike_wr && fifo_full;
    assign fifo_push  = spike_wr || marker_wr;
    assign wr_entry   = spike_wr ? '{marker: 1'b0,
                                     base:   CTRL_POST_NEURON_ADDRESS[9:2],
                                     mask:   NEUR_EVENT_OUT}
                                 : MARKER_ENTRY;

    aer_evt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .push   (fifo_push),
        .wr_dat (wr_entry),
        .pop    (fifo_pop),
        .rd_dat (rd_entry),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ack_meta    <= 1'b0;
            ack_s       <= 1'b0;
            tstep_q     <= 1'b0;
            marker_pend <= 1'b0;
        end else begin
            ack_meta    <= aer.AER_ACK;
            ack_s       <= ack_meta;
            tstep_q     <= CTRL_TSTEP_EVENT;
            marker_pend <= (marker_pend && !marker_wr) ||
                           (tstep_rise && !SPI_GATE_ACTIVITY_sync);
        end
    end

    // clear takes precedence over a drop in the same cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (CLR_STATUS) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != DROP_SAT) drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    always_comb begin
        low_idx = 2'd0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (ser_q.mask[i]) low_idx = i[1:0];
        end
    end
    assign low_bit = 4'b0001 << low_idx;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            ser_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            ser_q   <= ser_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ser_d    = ser_q;
        req_d    = req_q;
        addr_d   = addr_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ser_d    = rd_entry;
                    state_d  = ST_SEL;
                end
            end
            ST_SEL: begin
                addr_d = event_addr(ser_q, low_idx);
                if (!ser_q.marker) ser_d.mask = ser_q.mask & ~low_bit;
                req_d   = 1'b1;
                state_d = ST_REQ_HI;
            end
            ST_REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = ST_ACK_LO;
                end
            end
            ST_ACK_LO: begin
                if (!ack_s) begin
                    if ((|ser_q.mask) && !ser_q.marker) begin
                        state_d = ST_SEL;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        ser_d    = rd_entry;
                        state_d  = ST_SEL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign aer.AER_REQ  = req_q;
    assign aer.AER_ADDR = addr_q;
    assign AER_BUSY     = !fifo_empty || (state_q != ST_IDLE);
    assign FIFO_EMPTY   = fifo_empty;
    assign OVERFLOW     = overflow_q;
    assign DROP_CNT     = drop_cnt_q;

endmodule

// File: tb/tb_aer_spike_encoder.sv
// Directed + randomized bench for aer_spike_encoder with a 4-phase receiver and an event-list model.
module tb_aer_spike_encoder;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic [3:0] NEUR_EVENT_OUT = '0;
    logic [9:0] CTRL_POST_NEURON_ADDRESS = '0;
    logic       CTRL_TSTEP_EVENT = 1'b0;
    logic       SPI_GATE_ACTIVITY_sync = 1'b0;
    logic       CLR_STATUS = 1'b0;
    logic       AER_BUSY, FIFO_EMPTY, OVERFLOW;
    logic [7:0] DROP_CNT;

    aer_spike_encoder_if aer_if ();

    aer_spike_encoder #(.FIFO_DEPTH(16), .FIFO_AW(4)) dut (
        .CLK                      (CLK),
        .RST_N                    (RST_N),
        .NEUR_EVENT_OUT           (NEUR_EVENT_OUT),
        .CTRL_POST_NEURON_ADDRESS (CTRL_POST_NEURON_ADDRESS),
        .CTRL_TSTEP_EVENT         (CTRL_TSTEP_EVENT),
        .SPI_GATE_ACTIVITY_sync   (SPI_GATE_ACTIVITY_sync),
        .CLR_STATUS               (CLR_STATUS),
        .aer                      (aer_if.master),
        .AER_BUSY                 (AER_BUSY),
        .FIFO_EMPTY               (FIFO_EMPTY),
        .OVERFLOW                 (OVERFLOW),
        .DROP_CNT                 (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    int          tests = 0;
    int          fails = 0;
    logic [10:0] rx_q[$];
    logic [10:0] exp_q[$];
    bit          resp_en = 1'b0;
    int          ack_dly = 0;
    int          hs_done = 0;
    int          stab_err = 0;
    logic        prev_req = 1'b0;
    logic [10:0] prev_addr = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Receiver: record ADDR on REQ, raise ACK after ack_dly, drop it ack_dly after REQ falls
    initial begin
        aer_if.AER_ACK = 1'b0;
        forever begin
            @(negedge CLK);
            if (resp_en && aer_if.AER_REQ && !aer_if.AER_ACK) begin
                rx_q.push_back(aer_if.AER_ADDR);
                repeat (ack_dly) @(negedge CLK);
                aer_if.AER_ACK = 1'b1;
                for (int n = 0; n < 2000 && aer_if.AER_REQ; n++) @(negedge CLK);
                repeat (ack_dly) @(negedge CLK);
                aer_if.AER_ACK = 1'b0;
                hs_done++;
            end
        end
    end

    always @(negedge CLK) begin
        if (prev_req && aer_if.AER_REQ && aer_if.AER_ADDR !== prev_addr) stab_err <= stab_err + 1;
        prev_req  <= aer_if.AER_REQ;
        prev_addr <= aer_if.AER_ADDR;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Each set bit is one event, lowest neuron index first
    task automatic model_word(input logic [3:0] m, input logic [9:0] a);
        for (int b = 0; b < 4; b++)
            if (m[b]) exp_q.push_back({1'b0, a[9:2], 2'(b)});
    endtask

    task automatic put_word(input logic [3:0] m, input logic [9:0] a);
        NEUR_EVENT_OUT = m;
        CTRL_POST_NEURON_ADDRESS = a;
        @(negedge CLK);
    endtask

    task automatic wait_idle(input string tag, input int max);
        int n;
        n = 0;
        while ((AER_BUSY || aer_if.AER_REQ || aer_if.AER_ACK) && n < max) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < max), 1);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ev%0d", tag, i), rx_q[i], exp_q[i]);
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int hs0;
        int n;
        int mk;
        logic [3:0] m;
        logic [9:0] a;

        // reset state
        #1 RST_N = 1'b0;
        @(negedge CLK);
        check("rst_req", aer_if.AER_REQ, 0);
        check("rst_addr", aer_if.AER_ADDR, 0);
        check("rst_busy", AER_BUSY, 0);
        check("rst_empty", FIFO_EMPTY, 1);
        check("rst_ovf", OVERFLOW, 0);
        check("rst_drop", DROP_CNT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // single word, immediate ACK, latency k+2
        resp_en = 1'b1;
        ack_dly = 0;
        hs0 = hs_done;
        NEUR_EVENT_OUT = 4'b1010;
        CTRL_POST_NEURON_ADDRESS = 10'h014;
        model_word(4'b1010, 10'h014);
        @(posedge CLK);
        @(negedge CLK);
        NEUR_EVENT_OUT = '0;
        @(posedge CLK); #1;
        check("lat_k1_req", aer_if.AER_REQ, 0);
        @(posedge CLK); #1;
        check("lat_k2_req", aer_if.AER_REQ, 1);
        check("lat_k2_addr", aer_if.AER_ADDR, 11'h015);
        @(negedge CLK);
        wait_idle("single", 500);
        compare_stream("single");
        check("single_hs", hs_done - hs0, 2);
        check("single_empty", FIFO_EMPTY, 1);
        check("single_busy", AER_BUSY, 0);

        // spike and time-step rise in the same cycle
        NEUR_EVENT_OUT = 4'b0001;
        CTRL_POST_NEURON_ADDRESS = 10'h000;
        CTRL_TSTEP_EVENT = 1'b1;
        model_word(4'b0001, 10'h000);
        exp_q.push_back(11'h400);
        @(negedge CLK);
        NEUR_EVENT_OUT = '0;
        wait_idle("marker", 500);
        CTRL_TSTEP_EVENT = 1'b0;
        compare_stream("marker");

        // overflow with the receiver stalled
        resp_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            put_word(4'b0001, 10'(i * 4));
            if (i < 17) model_word(4'b0001, 10'(i * 4));
        end
        NEUR_EVENT_OUT = '0;
        repeat (3) @(negedge CLK);
        check("ovf_flag", OVERFLOW, 1);
        check("ovf_drop", DROP_CNT, 1);
        check("ovf_req_held", aer_if.AER_REQ, 1);
        check("ovf_addr_held", aer_if.AER_ADDR, 11'h000);
        check("ovf_not_empty", FIFO_EMPTY, 0);
        CLR_STATUS = 1'b1;
        @(negedge CLK);
        CLR_STATUS = 1'b0;
        check("clr_ovf", OVERFLOW, 0);
        check("clr_drop", DROP_CNT, 0);

        // saturation, then clear colliding with a drop
        for (int i = 0; i < 300; i++) put_word(4'b1111, 10'h3FC);
        NEUR_EVENT_OUT = '0;
        @(negedge CLK);
        check("sat_drop", DROP_CNT, 8'hFF);
        check("sat_ovf", OVERFLOW, 1);
        CLR_STATUS = 1'b1;
        put_word(4'b0110, 10'h3FC);
        CLR_STATUS = 1'b0;
        NEUR_EVENT_OUT = '0;
        check("clrwin_ovf", OVERFLOW, 0);
        check("clrwin_drop", DROP_CNT, 0);
        resp_en = 1'b1;
        wait_idle("drain", 3000);
        compare_stream("drain");

        // reset while REQ is high
        resp_en = 1'b0;
        put_word(4'b0011, 10'h020);
        put_word(4'b0100, 10'h040);
        NEUR_EVENT_OUT = '0;
        n = 0;
        while (!aer_if.AER_REQ && n < 50) begin
            @(negedge CLK);
            n++;
        end
        check("midrst_req_seen", aer_if.AER_REQ, 1);
        #2 RST_N = 1'b0;
        #1;
        check("midrst_req", aer_if.AER_REQ, 0);
        check("midrst_empty", FIFO_EMPTY, 1);
        @(negedge CLK);
        RST_N = 1'b1;
        rx_q.delete();
        exp_q.delete();
        resp_en = 1'b1;
        repeat (50) @(negedge CLK);
        check("midrst_stale", rx_q.size(), 0);
        check("midrst_busy", AER_BUSY, 0);

        // gate blocks new words and markers
        SPI_GATE_ACTIVITY_sync = 1'b1;
        CTRL_TSTEP_EVENT = 1'b1;
        for (int i = 0; i < 3; i++) put_word(4'b0101, 10'h100);
        CTRL_TSTEP_EVENT = 1'b0;
        put_word(4'b0011, 10'h104);
        NEUR_EVENT_OUT = '0;
        SPI_GATE_ACTIVITY_sync = 1'b0;
        repeat (40) @(negedge CLK);
        check("gate_events", rx_q.size(), 0);
        check("gate_empty", FIFO_EMPTY, 1);
        rx_q.delete();

        // an entry queued before the gate still drains
        ack_dly = 2;
        put_word(4'b1001, 10'h0A8);
        model_word(4'b1001, 10'h0A8);
        SPI_GATE_ACTIVITY_sync = 1'b1;
        put_word(4'b1111, 10'h0FC);
        NEUR_EVENT_OUT = '0;
        wait_idle("gate_drain", 500);
        SPI_GATE_ACTIVITY_sync = 1'b0;
        compare_stream("gate_drain");

        // randomized bursts, slow receiver, pointer wrap; marker lands after each burst
        ack_dly = 5;
        for (int burst = 0; burst < 5; burst++) begin
            mk = $urandom_range(0, 7);
            for (int j = 0; j < 8; j++) begin
                m = 4'($urandom_range(1, 15));
                a = 10'($urandom_range(0, 1023));
                if (j == mk) CTRL_TSTEP_EVENT = 1'b1;
                model_word(m, a);
                put_word(m, a);
            end
            NEUR_EVENT_OUT = '0;
            exp_q.push_back(11'h400);
            wait_idle($sformatf("wrap_b%0d", burst), 3000);
            CTRL_TSTEP_EVENT = 1'b0;
            @(negedge CLK);
        end
        compare_stream("wrap");
        check("wrap_drop", DROP_CNT, 0);
        check("wrap_empty", FIFO_EMPTY, 1);
        check("addr_stability", stab_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
